// File: rtl/sar_pkg.sv
// sar_pkg -- shared definitions for the successive-approximation search.
//   sar_state_t : FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3, ERR=4)
//   PROBE_W     : width of the probe counter
package sar_pkg;

    localparam int PROBE_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } sar_state_t;

endpackage

// File: rtl/sar_mid.sv
// sar_mid -- midpoint of two unsigned values, (a + b) >> 1.
//   a, b : WIDTH-bit operands
//   mid  : WIDTH-bit midpoint; the sum is formed at WIDTH+1 bits so it
//          never overflows.
module sar_mid #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mid
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        mid = WIDTH'(sum >> 1);
    end

endmodule

// File: rtl/sar_search4.sv
// sar_search4 -- binary search of an external secret through a comparator.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : begin a search (honoured in IDLE, DONE and ERR only)
//   cmp_eq  : comparator flag, secret == guess
//   cmp_lt  : comparator flag, secret <  guess
//   cmp_gt  : comparator flag, secret >  guess
//   guess   : registered value presented to the comparator
//   result  : located value, held until the next start
//   probes  : comparisons sampled in the current/last search (saturates)
//   busy    : search in progress
//   done    : search succeeded (sticky until next start)
//   err     : search failed (sticky until next start)
// Build option: define SAR_ONEHOT_CHECK_EN to treat more than one asserted
// comparator flag as an error; otherwise flags resolve eq > lt > gt.
module sar_search4
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cmp_eq,
    input  logic               cmp_lt,
    input  logic               cmp_gt,
    output logic [WIDTH-1:0]   guess,
    output logic [WIDTH-1:0]   result,
    output logic [PROBE_W-1:0] probes,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    sar_state_t         state, state_nx;
    logic [WIDTH-1:0]   lo, lo_nx;
    logic [WIDTH-1:0]   hi, hi_nx;
    logic [WIDTH-1:0]   guess_nx, result_nx;
    logic [PROBE_W-1:0] probes_nx;
    logic               busy_nx, done_nx, err_nx;

    logic [WIDTH-1:0]   guess_dec, guess_inc;
    logic [WIDTH-1:0]   mid_a, mid_b, mid;

    // The neighbours are only meaningful when they stay inside [lo, hi];
    // at the edges they fall back to guess so no wrap is ever produced.
    always_comb begin
        guess_dec = (guess != lo) ? guess - 1'b1 : guess;
        guess_inc = (guess != hi) ? guess + 1'b1 : guess;
    end

    // One shared midpoint unit: the full range on start, otherwise the
    // half selected by the comparator (lt wins over gt).
    always_comb begin
        mid_a = '0;
        mid_b = MAX_VAL;
        if (state == SAMPLE) begin
            if (cmp_lt) begin
                mid_a = lo;
                mid_b = guess_dec;
            end else begin
                mid_a = guess_inc;
                mid_b = hi;
            end
        end
    end

    sar_mid #(.WIDTH(WIDTH)) u_mid (
        .a   (mid_a),
        .b   (mid_b),
        .mid (mid)
    );

`ifdef SAR_ONEHOT_CHECK_EN
    logic multi_flag;
    always_comb begin
        multi_flag = (cmp_eq & cmp_lt) | (cmp_eq & cmp_gt) | (cmp_lt & cmp_gt);
    end
`endif

    always_comb begin
        state_nx  = state;
        lo_nx     = lo;
        hi_nx     = hi;
        guess_nx  = guess;
        result_nx = result;
        probes_nx = probes;
        busy_nx   = busy;
        done_nx   = done;
        err_nx    = err;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    lo_nx     = '0;
                    hi_nx     = MAX_VAL;
                    guess_nx  = mid;
                    probes_nx = '0;
                    done_nx   = 1'b0;
                    err_nx    = 1'b0;
                    busy_nx   = 1'b1;
                    state_nx  = DRIVE;
                end
            end

            DRIVE: begin
                state_nx = SAMPLE;
            end

            SAMPLE: begin
                probes_nx = (probes == '1) ? probes : probes + 1'b1;
`ifdef SAR_ONEHOT_CHECK_EN
                if (multi_flag) begin
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = ERR;
                end else
`endif
                if (cmp_eq) begin
                    result_nx = guess;
                    done_nx   = 1'b1;
                    busy_nx   = 1'b0;
                    state_nx  = DONE;
                end else if (cmp_lt) begin
                    if (guess == lo) begin
                        err_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = ERR;
                    end else begin
                        hi_nx    = guess_dec;
                        guess_nx = mid;
                        state_nx = DRIVE;
                    end
                end else if (cmp_gt) begin
                    if (guess == hi) begin
                        err_nx   = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = ERR;
                    end else begin
                        lo_nx    = guess_inc;
                        guess_nx = mid;
                        state_nx = DRIVE;
                    end
                end else begin
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = ERR;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= MAX_VAL;
            guess  <= '0;
            result <= '0;
            probes <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            lo     <= lo_nx;
            hi     <= hi_nx;
            guess  <= guess_nx;
            result <= result_nx;
            probes <= probes_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            err    <= err_nx;
        end
    end

endmodule

// File: doc/sar_search4.md
SAR_SEARCH4 -- requirements
Module: sar_search4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of the searched value, guess and result.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a search.
REQ-005 The block SHALL have port cmp_eq, input, 1 bit, from the external comparator: secret == guess.
REQ-006 The block SHALL have port cmp_lt, input, 1 bit, from the external comparator: secret < guess.
REQ-007 The block SHALL have port cmp_gt, input, 1 bit, from the external comparator: secret > guess.
REQ-008 The block SHALL have port guess, output, WIDTH bits, the registered value driven to the comparator's b operand.
REQ-009 The block SHALL have port result, output, WIDTH bits, the located value.
REQ-010 The block SHALL have port probes, output, 3 bits, the number of comparisons sampled in the current or last search.
REQ-011 The block SHALL have ports busy, done and err, outputs, 1 bit each: searching, success (sticky) and failure (sticky).

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE and ERR, with 2 cycles per probe (DRIVE settles the comparator, SAMPLE evaluates).
REQ-013 In IDLE, DONE or ERR, start=1 SHALL on the same edge load lo=0, hi=2^WIDTH-1, guess=(lo+hi)>>1, probes=0, clear done/err, set busy and go to DRIVE.
REQ-014 start SHALL be ignored in DRIVE and SAMPLE.
REQ-015 DRIVE SHALL go unconditionally to SAMPLE with guess held.
REQ-016 In SAMPLE, probes SHALL increment (saturating at 7) and flags SHALL be evaluated.
REQ-017 On cmp_eq: result=guess, done=1, busy=0, go to DONE.
REQ-018 On cmp_lt with guess==lo: err=1, busy=0, go to ERR; otherwise hi=guess-1, guess=(lo+guess-1)>>1, go to DRIVE.
REQ-019 On cmp_gt with guess==hi: err=1, busy=0, go to ERR; otherwise lo=guess+1, guess=(guess+1+hi)>>1, go to DRIVE.
REQ-020 Midpoint sums SHALL be computed at WIDTH+1 bits with no overflow; guess-1 and guess+1 are evaluated only when they are in range.
REQ-021 A correct comparator SHALL yield done within WIDTH+1 probes, i.e. at most 2*(WIDTH+1) cycles after start.
REQ-022 In SAMPLE with no flag asserted: err=1, go to ERR.
REQ-023 guess and result SHALL hold their values in DONE and ERR until the next start.

Reset
REQ-024 When rst_n=0 at a rising edge, the block SHALL enter IDLE with guess=0, result=0, probes=0, busy=0, done=0, err=0, lo=0, hi=2^WIDTH-1, regardless of the current state, including mid-search.
REQ-025 start SHALL NOT be honoured in any cycle where rst_n=0.

Configuration
REQ-026 With SAR_ONEHOT_CHECK_EN defined, SAMPLE with more than one of cmp_eq/cmp_lt/cmp_gt asserted SHALL set err and go to ERR.
REQ-027 Without SAR_ONEHOT_CHECK_EN, multiple flags SHALL resolve by priority eq > lt > gt, and only REQ-018/019/022 produce err.

Structure
REQ-028 Package sar_pkg SHALL hold the state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3, ERR=4, 3 bits) and the PROBE_W=3 constant.
REQ-029 Sub-module sar_mid SHALL compute the (lo+hi)>>1 midpoint at WIDTH+1 bits; everything else stays in sar_search4.

Verification
REQ-030 Secret 7, start pulsed at edge 0 -> guess=7, done=1 after edge 2, result=7, probes=1.
REQ-031 Secret 15 -> guesses 7,11,13,14,15; done after 10 edges after start; probes=5; result=15.
REQ-032 Secret 0 -> guesses 7,3,1,0; probes=4; result=0; err=0.
REQ-033 Comparator forced to cmp_gt=1 permanently -> guesses 7,11,13,14,15, then err=1, done=0, state ERR, probes=5.
REQ-034 Flags lt=gt=1 on the first probe -> with SAR_ONEHOT_CHECK_EN err=1 at probes=1; without it, hi=6 and the next guess is 3.
REQ-035 rst_n=0 during the second DRIVE of a search for 15 -> all outputs 0 next cycle; a subsequent start completes normally with result 15.
